// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the multicycle memory sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_sequencer.sv
// Multicycle fetch / load-store / retire sequencer over one shared variable-latency memory.
// Optional MEM_TIMEOUT_EN adds a bounded ack wait with a sticky bus_err and a HALT state.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] cpu_pc,
  input  logic [XLEN-1:0] cpu_alu_result,
  input  logic [XLEN-1:0] cpu_write_data,
  input  logic            cpu_mem_write,
  output logic [XLEN-1:0] cpu_instr,
  output logic [XLEN-1:0] cpu_read_data,
  output logic            cpu_en,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            bus_err
);

  state_t          state, state_nx;
  logic            boot_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] rdata_q;
  logic            ack_ok;
  logic            is_load;
  logic            is_mem_op;
  logic            timeout_hit;

  assign is_load   = (instr_q[6:0] == OPC_LOAD);
  assign is_mem_op = is_load || (instr_q[6:0] == OPC_STORE);
  assign ack_ok    = mem_req && mem_ack;

  // boot_q keeps mem_req low for the first cycle after reset so an abandoned
  // transfer is visibly terminated before the next fetch starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= FETCH;
      boot_q <= 1'b1;
    end else begin
      state  <= state_nx;
      boot_q <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (ack_ok) state_nx = EXEC;
      EXEC:    state_nx = is_mem_op ? MEM : FETCH;
      MEM:     if (ack_ok) state_nx = COMMIT;
      COMMIT:  state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
    if (timeout_hit) state_nx = HALT;
  end

  always_comb begin
    mem_req   = !boot_q && ((state == FETCH) || (state == MEM));
    mem_we    = !boot_q && (state == MEM) && cpu_mem_write;
    mem_addr  = (state == MEM) ? cpu_alu_result : cpu_pc;
    mem_wdata = cpu_write_data;
    cpu_en    = ((state == EXEC) && !is_mem_op) || (state == COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= XLEN'(NOP_INSTR);
      rdata_q <= '0;
    end else begin
      if ((state == FETCH) && ack_ok) instr_q <= mem_rdata;
      if ((state == MEM) && ack_ok && is_load) rdata_q <= mem_rdata;
    end
  end

  assign cpu_instr     = instr_q;
  assign cpu_read_data = rdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;

  // Limit is hit on the edge that would complete the TIMEOUT_CYCLES-th unacked wait.
  assign timeout_hit = mem_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!mem_req || mem_ack) wait_cnt <= '0;
      else                     wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed self-checking bench for mem_sequencer; each scenario checks its own expectations.
module tb_mem_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_pc, cpu_alu_result, cpu_write_data;
  logic        cpu_mem_write;
  logic [31:0] cpu_instr, cpu_read_data;
  logic        cpu_en, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h1000_2103;
  localparam logic [31:0] SW   = 32'h2050_2023;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  mem_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cpu_pc(cpu_pc), .cpu_alu_result(cpu_alu_result),
    .cpu_write_data(cpu_write_data), .cpu_mem_write(cpu_mem_write),
    .cpu_instr(cpu_instr), .cpu_read_data(cpu_read_data), .cpu_en(cpu_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one cycle, apply memory response for it, then settle at the negedge.
  task automatic step(input logic ack, input logic [31:0] rd);
    @(posedge clk); #1;
    mem_ack = ack; mem_rdata = rd;
    @(negedge clk);
  endtask

  // Reset sampled at one edge; returns at the negedge of the cycle right after it.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_core(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd, input logic mw);
    cpu_pc = pc; cpu_alu_result = alu; cpu_write_data = wd; cpu_mem_write = mw;
  endtask

  task automatic test_reset();
    set_core(32'h0, 32'h0, 32'h0, 1'b0);
    do_reset();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", mem_we); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_en got %0b exp 0", cpu_en); end
    checks++; if (cpu_instr !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", cpu_instr, NOP); end
    checks++; if (cpu_read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", cpu_read_data); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_buserr got %0b exp 0", bus_err); end
  endtask

  task automatic test_addi();
    set_core(32'h0, 32'h0, 32'h0, 1'b0);
    do_reset();
    step(1'b1, ADDI);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL addi_fetch_req got %0b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL addi_fetch_addr got %h exp 0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL addi_fetch_we got %0b exp 0", mem_we); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL addi_fetch_en got %0b exp 0", cpu_en); end
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL addi_exec_en got %0b exp 1", cpu_en); end
    checks++; if (cpu_instr !== ADDI) begin errors++; $display("FAIL addi_instr got %h exp %h", cpu_instr, ADDI); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL addi_exec_req got %0b exp 0", mem_req); end
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL addi_en_width got %0b exp 0", cpu_en); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL addi_refetch_req got %0b exp 1", mem_req); end
  endtask

  task automatic test_load_wait();
    int en_seen = 0;
    set_core(32'h4, 32'h100, 32'h0, 1'b0);
    do_reset();
    step(1'b1, LW);
    en_seen += int'(cpu_en);
    step(1'b0, 32'h0);
    en_seen += int'(cpu_en);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_exec_req got %0b exp 0", mem_req); end
    step(1'b0, 32'h0);
    en_seen += int'(cpu_en);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin errors++; $display("FAIL lw_mem_req got req=%0b addr=%h we=%0b exp req=1 addr=100 we=0", mem_req, mem_addr, mem_we); end
    step(1'b0, 32'h0);
    en_seen += int'(cpu_en);
    step(1'b1, 32'hCAFE_F00D);
    en_seen += int'(cpu_en);
    checks++; if (cpu_read_data !== 32'h0) begin errors++; $display("FAIL lw_rdata_early got %h exp 0", cpu_read_data); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL lw_hold got req=%0b addr=%h exp req=1 addr=100", mem_req, mem_addr); end
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL lw_commit_en got %0b exp 1 at cycle 6", cpu_en); end
    checks++; if (cpu_read_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_rdata got %h exp cafef00d", cpu_read_data); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL lw_early_en got %0d pulses exp 0", en_seen); end
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL lw_next_fetch got en=%0b req=%0b addr=%h exp en=0 req=1 addr=4", cpu_en, mem_req, mem_addr); end
  endtask

  task automatic test_store();
    set_core(32'h8, 32'h200, 32'hDEAD_BEEF, 1'b1);
    do_reset();
    step(1'b1, SW);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h8) begin errors++; $display("FAIL sw_fetch got we=%0b addr=%h exp we=0 addr=8", mem_we, mem_addr); end
    step(1'b0, 32'h0);
    checks++; if (mem_we !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL sw_exec got we=%0b req=%0b exp 0 0", mem_we, mem_req); end
    step(1'b1, 32'h1234_5678);
    checks++; if (mem_we !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL sw_mem_we got we=%0b req=%0b exp 1 1", mem_we, mem_req); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sw_mem_addr got %h exp 200", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_mem_wdata got %h exp deadbeef", mem_wdata); end
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL sw_commit got en=%0b we=%0b exp 1 0", cpu_en, mem_we); end
    checks++; if (cpu_read_data !== 32'h0) begin errors++; $display("FAIL sw_no_capture got %h exp 0", cpu_read_data); end
    step(1'b0, 32'h0);
    checks++; if (mem_we !== 1'b0 || mem_req !== 1'b1 || cpu_en !== 1'b0) begin errors++; $display("FAIL sw_refetch got we=%0b req=%0b en=%0b exp 0 1 0", mem_we, mem_req, cpu_en); end
  endtask

  task automatic test_reset_mid();
    set_core(32'hC, 32'h100, 32'h0, 1'b0);
    do_reset();
    step(1'b1, LW);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_in_mem got req=%0b exp 1", mem_req); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || cpu_en !== 1'b0) begin errors++; $display("FAIL rmid_idle got req=%0b en=%0b exp 0 0", mem_req, cpu_en); end
    checks++; if (cpu_instr !== NOP) begin errors++; $display("FAIL rmid_instr got %h exp %h", cpu_instr, NOP); end
    step(1'b0, 32'h0);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hC || cpu_en !== 1'b0) begin errors++; $display("FAIL rmid_fetch got req=%0b addr=%h en=%0b exp 1 c 0", mem_req, mem_addr, cpu_en); end
  endtask

  task automatic test_spurious_ack();
    set_core(32'h10, 32'h100, 32'h0, 1'b0);
    do_reset();
    step(1'b1, LW);
    step(1'b1, 32'hBAD0_BAD0);
    checks++; if (cpu_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL sp_exec got en=%0b req=%0b exp 0 0", cpu_en, mem_req); end
    step(1'b0, 32'h0);
    checks++; if (cpu_instr !== LW || mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL sp_exec_ack got instr=%h req=%0b addr=%h exp %h 1 100", cpu_instr, mem_req, mem_addr, LW); end
    step(1'b1, 32'h1111_1111);
    step(1'b1, 32'h2222_2222);
    checks++; if (cpu_en !== 1'b1 || cpu_read_data !== 32'h1111_1111) begin errors++; $display("FAIL sp_commit got en=%0b rdata=%h exp 1 11111111", cpu_en, cpu_read_data); end
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b0 || cpu_read_data !== 32'h1111_1111 || cpu_instr !== LW || mem_addr !== 32'h10) begin errors++; $display("FAIL sp_after got en=%0b rdata=%h instr=%h addr=%h exp 0 11111111 %h 10", cpu_en, cpu_read_data, cpu_instr, mem_addr, LW); end
  endtask

  task automatic test_timeout();
    int en_seen = 0;
    set_core(32'h20, 32'h0, 32'h0, 1'b0);
    do_reset();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0);
      checks++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL to_wait%0d got req=%0b err=%0b exp 1 0", i, mem_req, bus_err); end
    end
    step(1'b1, ADDI);
    checks++; if (bus_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL to_halt got err=%0b req=%0b exp 1 0", bus_err, mem_req); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ADDI);
      en_seen += int'(cpu_en) + int'(mem_req);
    end
    checks++; if (en_seen !== 0 || bus_err !== 1'b1) begin errors++; $display("FAIL to_hold got activity=%0d err=%0b exp 0 1", en_seen, bus_err); end
    do_reset();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_clear got err=%0b exp 0", bus_err); end
`else
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0);
      en_seen += int'(cpu_en) + int'(bus_err) + int'(!mem_req);
    end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL nto_wait got %0d deviations exp 0", en_seen); end
    step(1'b1, ADDI);
    step(1'b0, 32'h0);
    checks++; if (cpu_en !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL nto_late_ack got en=%0b err=%0b exp 1 0", cpu_en, bus_err); end
`endif
  endtask

  initial begin
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_core(32'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_reset_mid();
    test_spurious_ack();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
